clk_div_bank: RTL and testbench
===============================

Name: clk_div_bank

Overview:
- Synchronous, parametrised successor to the ripple divide-by-2^n chain. Provides TAPS fully synchronous power-of-two taps plus NUM_CH independently programmable integer dividers, each with a near-50% divided level output and a one-cycle tick strobe.
- Sits beside the system clock root and feeds enables to downstream timing blocks. Nothing downstream is clocked by a divided output; all consumers run on clk and use the ticks/levels as enables.

Parameters:
- NUM_CH, 4, number of programmable divider channels (1..16).
- CNT_W, 16, divisor/counter width per channel.
- TAPS, 6, number of power-of-two taps (tap i = clk/2^(i+1)).
- DEFAULT_DIV, 2, divisor loaded into every channel on reset.
- CH_W, derived = max(1, clog2(NUM_CH)), channel select width (localparam).

Ports:
- clk  in  1  system clock; all flops on rising edge.
- reset  in  1  synchronous reset, active-high.
- sync_i  in  1  phase-align pulse: restarts all channel counters and the tap counter.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  CH_W  channel addressed by cfg_we.
- cfg_div  in  CNT_W  new divisor value.
- cfg_pending_o  out  NUM_CH  bit c = channel c holds an unapplied divisor.
- tap_o  out  TAPS  power-of-two divided levels.
- div_o  out  NUM_CH  divided level per channel.
- tick_o  out  NUM_CH  one-cycle strobe per channel period.

Behaviour:
- Reset (sampled at clk edge):
  - tap counter = 0, tap_o = 0.
  - every channel: D = DEFAULT_DIV, cnt = 0, pending cleared.
  - div_o = 0, tick_o = 0, cfg_pending_o = 0.
  - Reset mid-period discards pending writes.
- Taps:
  - TAPS-bit free-running up-counter; tap_o = counter value, registered.
  - tap_o[i] toggles every 2^i cycles; wraps at 2^TAPS-1 -> 0.
  - sync_i clears the counter.
- Channel counter, for D >= 2:
  - cnt counts 0..D-1, wrapping to 0.
  - div_o = 1 while cnt < ceil(D/2), else 0.
  - tick_o = 1 only while cnt == D-1.
  - Both outputs come straight from flops (next-state decode registered), so they are glitch-free.
  - Period is exactly D cycles: high ceil(D/2), low floor(D/2).
  - The first cycle after reset release has cnt = 0, so div_o = 1.
- D == 1: tick_o = 1 every cycle, div_o = 1 constantly.
- D == 0: channel disabled; cnt held at 0, div_o = 0, tick_o = 0.
- Divisor write:
  - cfg_we with cfg_ch < NUM_CH stores cfg_div in the pending register and sets pending.
  - cfg_ch >= NUM_CH is ignored.
  - A write to an already-pending channel overwrites it (last write wins).
- Apply point: pending value loads into D, cnt <= 0 and pending clears on the clock edge where any of these holds:
  - cnt == D-1 (end of period);
  - D is 0 or 1;
  - sync_i = 1.
  - No truncated or stretched period is ever emitted, except on sync_i.
- Write on an apply edge: the incoming cfg_div is applied directly on that edge, and pending ends 0.
- sync_i:
  - all cnt <= 0 and tap counter <= 0 on that edge;
  - the next cycle has div_o = 1 and tick_o = 0 for D >= 2, so all channels are phase-aligned.
- Priority, highest first: reset > sync_i > period wrap > count.
- Arithmetic: ceil(D/2) = (D+1)>>1, computed at CNT_W+1 bits to avoid overflow at D = 2^CNT_W-1. All compares are unsigned.

Decomposition:
- Shared package clk_div_pkg holds:
  - localparam function for CH_W (clog2);
  - constants DIV_DISABLED = 0 and DIV_PASS = 1.
- One sub-module, clk_div_chan (parameter CNT_W, DEFAULT_DIV), holds per channel: D, pending register, cnt, div/tick flops.
- clk_div_bank instantiates NUM_CH copies via generate, plus the tap counter and write-address decode.

Test Plan:
- Reset, defaults: hold reset 3 cycles, release -> every div_o toggles 1,0,1,0 each cycle; tick_o high on every cycle with cnt = 1; tap_o counts 1,2,3..; tap_o[5] first rises after 32 cycles.
- Odd divisor: write ch1 = 5 -> after the current period ends, div_o[1] is high 3 / low 2 cycles; tick_o[1] exactly one cycle per 5; cfg_pending_o[1] high from the write until the apply edge.
- Deferred apply: ch0 D = 10 at cnt = 3, write 4 -> period still completes 10 cycles, then 4-cycle periods; a second write of 6 before apply -> 6 takes effect, 4 never seen.
- Disable/pass: write ch2 = 0 -> div_o[2] = tick_o[2] = 0 after the period end; then write 1 -> applied next edge, tick_o[2] = 1 every cycle.
- sync_i with mixed divisors (3, 4, 7, 16): pulse sync_i -> next cycle all div_o = 1, tap_o = 0; ticks coincide at cycle 84 (lcm 3,4,7 = 84; 16 independent).
- Boundary: CNT_W = 4, D = 15 -> 8 high / 7 low, no overflow. Write with cfg_ch = NUM_CH -> no state change. Reset mid-pending -> cfg_pending_o = 0 and D = DEFAULT_DIV.

Source files
------------

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared constants, types and helpers for the clk_div_bank
//                divider bank and its per-channel divider.
//  Revision    : 1.0 - initial synchronous release
// ============================================================================
package clk_div_pkg;

    // Divisor values with special meaning.
    // 0 parks the channel; 1 passes every cycle through as a tick.
    localparam int DIV_DISABLED = 0;
    localparam int DIV_PASS     = 1;

    // Registered outputs of one channel, decoded from its next state.
    typedef struct packed {
        logic lvl;
        logic tick;
    } div_out_t;

    // Channel-select width: at least one bit, even for a single channel.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_chan
//  Description : One programmable integer divider. Produces a near-50% level
//                and a one-cycle tick per period. New divisors are held
//                pending and only take effect on a period boundary, when the
//                channel is disabled/pass-through, or on a phase-align pulse.
//  Revision    : 1.0 - initial synchronous release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sync,
    input  logic             i_restart,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_pending,
    output logic             o_div,
    output logic             o_tick
);

    localparam logic [CNT_W-1:0] C_ZERO     = '0;
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DISABLED = CNT_W'(DIV_DISABLED);
    localparam logic [CNT_W-1:0] C_PASS     = CNT_W'(DIV_PASS);
    localparam logic [CNT_W-1:0] C_DEFAULT  = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_div;
    logic             r_tick;

    logic [CNT_W-1:0] w_d_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_pend_div_nxt;
    logic             w_pend_nxt;
    logic             w_wrap;
    logic             w_apply;
    div_out_t         w_out;

    // Level/tick for a given count and divisor. The half-period threshold is
    // formed one bit wider so D = all-ones does not wrap when rounded up.
    function automatic div_out_t decode(input logic [CNT_W-1:0] cnt,
                                        input logic [CNT_W-1:0] d);
        logic [CNT_W:0] half;
        div_out_t       res;
        half = ({1'b0, d} + {C_ZERO, 1'b1}) >> 1;
        res  = '0;
        if (d == C_DISABLED) begin
            res.lvl  = 1'b0;
            res.tick = 1'b0;
        end else if (d == C_PASS) begin
            res.lvl  = 1'b1;
            res.tick = 1'b1;
        end else begin
            res.lvl  = ({1'b0, cnt} < half);
            res.tick = (cnt == (d - C_ONE));
        end
        return res;
    endfunction

    // Next-state: apply point, divisor/pending update, counter advance and
    // output decode of the state the counter is about to enter.
    always_comb begin
        w_wrap         = (r_d > C_PASS) && (r_cnt == (r_d - C_ONE));
        w_apply        = w_wrap || (r_d <= C_PASS) || i_sync;
        w_d_nxt        = r_d;
        w_pend_div_nxt = r_pend_div;
        w_pend_nxt     = r_pend;
        if (w_apply) begin
            // A write landing on an apply edge bypasses the pending register.
            if (i_we) begin
                w_d_nxt = i_div;
            end else if (r_pend) begin
                w_d_nxt = r_pend_div;
            end
            w_pend_nxt = 1'b0;
        end else if (i_we) begin
            // Last write before the apply edge wins.
            w_pend_div_nxt = i_div;
            w_pend_nxt     = 1'b1;
        end
        // The first edge after reset parks the counter at 0 so the first
        // visible cycle starts a fresh period.
        w_cnt_nxt = (w_apply || i_restart) ? C_ZERO : (r_cnt + C_ONE);
        w_out     = decode(w_cnt_nxt, w_d_nxt);
    end

    // Channel state and glitch-free registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d        <= C_DEFAULT;
            r_cnt      <= C_ZERO;
            r_pend_div <= C_ZERO;
            r_pend     <= 1'b0;
            r_div      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_d        <= w_d_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend_div <= w_pend_div_nxt;
            r_pend     <= w_pend_nxt;
            r_div      <= w_out.lvl;
            r_tick     <= w_out.tick;
        end
    end

    assign o_pending = r_pend;
    assign o_div     = r_div;
    assign o_tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_bank
//  Description : Fully synchronous divider bank. A free-running tap counter
//                provides power-of-two levels; NUM_CH programmable channels
//                provide divided levels and tick strobes. All outputs are
//                enables for logic running on clk, never clocks themselves.
//  Revision    : 1.0 - initial synchronous release
// ============================================================================
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int CNT_W       = 16,
    parameter  int TAPS        = 6,
    parameter  int DEFAULT_DIV = 2,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync_i,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] cfg_pending_o,
    output logic [TAPS-1:0]   tap_o,
    output logic [NUM_CH-1:0] div_o,
    output logic [NUM_CH-1:0] tick_o
);

    localparam logic [TAPS-1:0] C_TAP_ONE = TAPS'(1);

    logic [TAPS-1:0]   r_tap;
    logic              r_run;
    logic              w_addr_ok;
    logic [NUM_CH-1:0] w_we;

    // Tap counter: free-running, realigned by sync_i.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tap <= '0;
        end else if (sync_i) begin
            r_tap <= '0;
        end else begin
            r_tap <= r_tap + C_TAP_ONE;
        end
    end

    // Marks the first edge after reset so channels restart at count 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Writes to channel numbers beyond the bank are dropped.
    always_comb begin
        w_addr_ok = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        assign w_we[c] = cfg_we && w_addr_ok && (cfg_ch == CH_W'(c));

        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk       (clk),
            .rst       (reset),
            .i_sync    (sync_i),
            .i_restart (~r_run),
            .i_we      (w_we[c]),
            .i_div     (cfg_div),
            .o_pending (cfg_pending_o[c]),
            .o_div     (div_o[c]),
            .o_tick    (tick_o[c])
        );
    end

    assign tap_o = r_tap;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_bank
//  Description : Directed self-checking bench for clk_div_bank: a vector table
//                for reset release and an odd-divisor write, then sequences
//                for deferred apply, disable/pass, sync, reset and a narrow
//                counter instance.
//  Revision    : 1.0
// ============================================================================
module tb_clk_div_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sync_i = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_div = '0;
    logic [3:0]  cfg_pending_o;
    logic [5:0]  tap_o;
    logic [3:0]  div_o;
    logic [3:0]  tick_o;

    // Narrow instance: one channel, 4-bit counter.
    logic        s_sync = 1'b0;
    logic        s_we = 1'b0;
    logic [0:0]  s_ch = '0;
    logic [3:0]  s_div = '0;
    logic [0:0]  s_pend;
    logic [1:0]  s_tap;
    logic [0:0]  s_lvl;
    logic [0:0]  s_tick;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_div_bank #(.NUM_CH(4), .CNT_W(16), .TAPS(6), .DEFAULT_DIV(2)) dut (
        .clk(clk), .reset(reset), .sync_i(sync_i), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_pending_o(cfg_pending_o),
        .tap_o(tap_o), .div_o(div_o), .tick_o(tick_o)
    );

    clk_div_bank #(.NUM_CH(1), .CNT_W(4), .TAPS(2), .DEFAULT_DIV(2)) dut_s (
        .clk(clk), .reset(reset), .sync_i(s_sync), .cfg_we(s_we),
        .cfg_ch(s_ch), .cfg_div(s_div), .cfg_pending_o(s_pend),
        .tap_o(s_tap), .div_o(s_lvl), .tick_o(s_tick)
    );

    typedef struct {
        logic        we;
        logic [1:0]  ch;
        logic [15:0] dv;
        logic [3:0]  e_div;
        logic [3:0]  e_tick;
        logic [3:0]  e_pend;
        logic [5:0]  e_tap;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic write_ch(input int ch, input int val);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_div = 16'(val);
        step();
        cfg_we  = 1'b0;
    endtask

    // Steps until the channel ticks (inclusive); n = cycles, hi = level-high cycles.
    task automatic run_period(input int ch, output int n, output int hi);
        n  = 0;
        hi = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            n++;
            if (div_o[ch]) hi++;
            if (tick_o[ch]) break;
        end
    endtask

    task automatic s_period(output int n, output int hi);
        n  = 0;
        hi = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            n++;
            if (s_lvl[0]) hi++;
            if (s_tick[0]) break;
        end
    endtask

    initial begin
        int n;
        int hi;
        int first;
        int t3;

        // Reset release with all channels at D=2, then ch1 <- 5.
        vecs[0] = '{1'b0, 2'd0, 16'd0, 4'hF, 4'h0, 4'h0, 6'd1};
        vecs[1] = '{1'b1, 2'd1, 16'd5, 4'h0, 4'hF, 4'h2, 6'd2};
        vecs[2] = '{1'b0, 2'd0, 16'd0, 4'hF, 4'h0, 4'h0, 6'd3};
        vecs[3] = '{1'b0, 2'd0, 16'd0, 4'h2, 4'hD, 4'h0, 6'd4};
        vecs[4] = '{1'b0, 2'd0, 16'd0, 4'hF, 4'h0, 4'h0, 6'd5};
        vecs[5] = '{1'b0, 2'd0, 16'd0, 4'h0, 4'hD, 4'h0, 6'd6};
        vecs[6] = '{1'b0, 2'd0, 16'd0, 4'hD, 4'h2, 4'h0, 6'd7};
        vecs[7] = '{1'b0, 2'd0, 16'd0, 4'h2, 4'hD, 4'h0, 6'd8};

        repeat (3) step();
        chk("rst_div", 32'(div_o), 0);
        chk("rst_tick", 32'(tick_o), 0);
        chk("rst_pend", 32'(cfg_pending_o), 0);
        chk("rst_tap", 32'(tap_o), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            cfg_we  = vecs[i].we;
            cfg_ch  = vecs[i].ch;
            cfg_div = vecs[i].dv;
            step();
            cfg_we  = 1'b0;
            chk($sformatf("vec%0d_div", i), 32'(div_o), 32'(vecs[i].e_div));
            chk($sformatf("vec%0d_tick", i), 32'(tick_o), 32'(vecs[i].e_tick));
            chk($sformatf("vec%0d_pend", i), 32'(cfg_pending_o), 32'(vecs[i].e_pend));
            chk($sformatf("vec%0d_tap", i), 32'(tap_o), 32'(vecs[i].e_tap));
        end

        // Tap MSB first rises at count 32, counter wraps 63 -> 0.
        n = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            n++;
            if (tap_o[5]) break;
        end
        chk("tap5_rise_steps", n, 24);
        chk("tap_at_32", 32'(tap_o), 32);
        repeat (31) step();
        chk("tap_at_63", 32'(tap_o), 63);
        step();
        chk("tap_wrap", 32'(tap_o), 0);

        // Deferred apply on ch0.
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        chk("sync1_div", 32'(div_o), 32'hF);
        chk("sync1_tick", 32'(tick_o), 0);
        chk("sync1_tap", 32'(tap_o), 0);
        write_ch(0, 10);
        chk("d10_pend", 32'(cfg_pending_o[0]), 1);
        chk("d10_tick_old", 32'(tick_o[0]), 1);
        step();
        chk("d10_applied_pend", 32'(cfg_pending_o[0]), 0);
        chk("d10_applied_div", 32'(div_o[0]), 1);
        chk("d10_applied_tick", 32'(tick_o[0]), 0);
        repeat (3) step();
        write_ch(0, 4);
        chk("w4_pend", 32'(cfg_pending_o[0]), 1);
        write_ch(0, 6);
        chk("w6_pend", 32'(cfg_pending_o[0]), 1);
        run_period(0, n, hi);
        chk("d10_tail_len", n, 4);
        chk("d10_tail_hi", hi, 0);
        chk("d10_tail_pend", 32'(cfg_pending_o[0]), 1);
        run_period(0, n, hi);
        chk("d6_len_a", n, 6);
        chk("d6_hi_a", hi, 3);
        chk("d6_pend_clr", 32'(cfg_pending_o[0]), 0);
        run_period(0, n, hi);
        chk("d6_len_b", n, 6);
        chk("d6_hi_b", hi, 3);

        // Disable then pass-through on ch2.
        write_ch(2, 0);
        repeat (2) step();
        chk("dis_pend", 32'(cfg_pending_o[2]), 0);
        chk("dis_div", 32'(div_o[2]), 0);
        chk("dis_tick", 32'(tick_o[2]), 0);
        step();
        chk("dis_div2", 32'(div_o[2]), 0);
        chk("dis_tick2", 32'(tick_o[2]), 0);
        write_ch(2, 1);
        chk("pass_div", 32'(div_o[2]), 1);
        chk("pass_tick", 32'(tick_o[2]), 1);
        chk("pass_pend", 32'(cfg_pending_o[2]), 0);
        step();
        chk("pass_tick2", 32'(tick_o[2]), 1);
        chk("pass_div2", 32'(div_o[2]), 1);

        // Mixed divisors 3,4,7,16 aligned by sync.
        write_ch(0, 3);
        write_ch(1, 4);
        write_ch(2, 7);
        write_ch(3, 16);
        for (int k = 0; k < 40; k++) begin
            if (cfg_pending_o == 4'h0) break;
            step();
        end
        chk("mix_pend_drained", 32'(cfg_pending_o), 0);
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        chk("sync2_div", 32'(div_o), 32'hF);
        chk("sync2_tick", 32'(tick_o), 0);
        chk("sync2_tap", 32'(tap_o), 0);
        first = 0;
        t3    = 0;
        for (int k = 2; k <= 84; k++) begin
            step();
            if (tick_o[3]) t3++;
            if (first == 0 && tick_o[2:0] == 3'b111) first = k;
        end
        chk("coincide_cycle", first, 84);
        chk("ch3_ticks", t3, 5);
        chk("tap_at_84", 32'(tap_o), 19);

        // Reset while a write is pending.
        step();
        write_ch(0, 9);
        chk("pre_rst_pend", 32'(cfg_pending_o[0]), 1);
        reset = 1'b1;
        step();
        chk("midrst_pend", 32'(cfg_pending_o), 0);
        chk("midrst_div", 32'(div_o), 0);
        chk("midrst_tap", 32'(tap_o), 0);
        reset = 1'b0;
        step();
        chk("rel_div", 32'(div_o), 32'hF);
        chk("rel_tap", 32'(tap_o), 1);
        step();
        chk("rel2_div", 32'(div_o), 0);
        chk("rel2_tick", 32'(tick_o), 32'hF);

        // Narrow instance: out-of-range write ignored, then D=15.
        s_we  = 1'b1;
        s_ch  = 1'b1;
        s_div = 4'd7;
        step();
        s_we  = 1'b0;
        chk("badch_pend", 32'(s_pend), 0);
        s_period(n, hi);
        s_period(n, hi);
        chk("badch_len", n, 2);
        chk("badch_hi", hi, 1);
        s_we  = 1'b1;
        s_ch  = 1'b0;
        s_div = 4'd15;
        step();
        s_we  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (s_pend == 1'b0) break;
            step();
        end
        chk("d15_pend_clr", 32'(s_pend), 0);
        s_period(n, hi);
        s_period(n, hi);
        chk("d15_len_a", n, 15);
        chk("d15_hi_a", hi, 8);
        s_period(n, hi);
        chk("d15_len_b", n, 15);
        chk("d15_hi_b", hi, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
